// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions for the serial link checker and its transmit-side generator.
package crc8_pkg;

  localparam int unsigned CRC_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CRC     = 2'd2
  } state_e;

  // Registered per-frame status pulses.
  typedef struct packed {
    logic done;
    logic ok;
    logic err;
    logic abort;
  } crc8_result_t;

  // One MSB-first LFSR step; x^8 is implicit in poly.
  function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] lfsr,
                                                  input logic             b,
                                                  input logic [CRC_W-1:0] poly);
    logic fb;
    fb = lfsr[CRC_W-1] ^ b;
    return {lfsr[CRC_W-2:0], 1'b0} ^ (fb ? poly : CRC_W'(0));
  endfunction

endpackage

// File: rtl/crc8_lfsr.sv
// CRC-8 LFSR register with load-from-INIT and step controls; exposes its next value.
module crc8_lfsr
  import crc8_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = 8'h07,
  parameter logic [CRC_W-1:0] INIT = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_bit,
  output logic [CRC_W-1:0] o_next_c
);

  logic [CRC_W-1:0] r_lfsr;
  logic [CRC_W-1:0] w_base;

  // Load and step may coincide: the first bit of a frame steps from INIT.
  always_comb begin
    w_base   = i_load ? INIT : r_lfsr;
    o_next_c = i_step ? crc8_step(w_base, i_bit, POLY) : w_base;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= INIT;
    end else begin
      r_lfsr <= o_next_c;
    end
  end

endmodule

// File: rtl/crc8_serial_checker.sv
// Receive-side CRC-8 frame checker: bit-serial payload plus 8 CRC bits, MSB first,
// with a registered pass/fail pulse one clock after the last CRC bit.
module crc8_serial_checker
  import crc8_pkg::*;
#(
  parameter int unsigned      DATA_BITS = 32,
  parameter logic [CRC_W-1:0] POLY      = 8'h07,
  parameter logic [CRC_W-1:0] INIT      = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             sof,
  output logic             busy,
  output logic             frame_done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             abort,
  output logic [CRC_W-1:0] err_cnt
);

  // The counter also indexes the 8 CRC bits, so it is never narrower than 3 bits.
  localparam int unsigned CNT_W_PL = $clog2(DATA_BITS + 1);
  localparam int unsigned CNT_W    = (CNT_W_PL > 3) ? CNT_W_PL : 3;

  localparam logic [CNT_W-1:0] LAST_PL   = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(CRC_W - 1);
  localparam logic [CNT_W-1:0] FIRST_CNT = (DATA_BITS == 1) ? CNT_W'(0) : CNT_W'(1);
  localparam state_e           FIRST_ST  = (DATA_BITS == 1) ? ST_CRC : ST_PAYLOAD;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  crc8_result_t     r_res;
  crc8_result_t     w_res_nxt;
  logic [CRC_W-1:0] r_err_cnt;
  logic [CRC_W-1:0] w_err_cnt_nxt;

  logic             w_start;
  logic             w_step;
  logic [CRC_W-1:0] w_lfsr_next;

  // A sof bit restarts the LFSR in any state; other bits only count inside a frame.
  assign w_start = bit_valid & sof;
  assign w_step  = bit_valid & (sof | (r_state != ST_IDLE));

  crc8_lfsr #(
    .POLY (POLY),
    .INIT (INIT)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_start),
    .i_step   (w_step),
    .i_bit    (bit_in),
    .o_next_c (w_lfsr_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_res     <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_res     <= w_res_nxt;
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_res_nxt     = '0;
    w_err_cnt_nxt = r_err_cnt;
    if (bit_valid) begin
      if (sof) begin
        w_state_nxt     = FIRST_ST;
        w_cnt_nxt       = FIRST_CNT;
        w_res_nxt.abort = (r_state != ST_IDLE);
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_state_nxt = ST_IDLE;
          end
          ST_PAYLOAD: begin
            if (r_cnt == LAST_PL) begin
              w_state_nxt = ST_CRC;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
          ST_CRC: begin
            if (r_cnt == LAST_CRC) begin
              w_state_nxt    = ST_IDLE;
              w_cnt_nxt      = '0;
              w_res_nxt.done = 1'b1;
              w_res_nxt.ok   = (w_lfsr_next == '0);
              w_res_nxt.err  = (w_lfsr_next != '0);
              if ((w_lfsr_next != '0) && (r_err_cnt != {CRC_W{1'b1}})) begin
                w_err_cnt_nxt = r_err_cnt + CRC_W'(1);
              end
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        endcase
      end
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign frame_done = r_res.done;
  assign crc_ok     = r_res.ok;
  assign crc_err    = r_res.err;
  assign abort      = r_res.abort;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_crc8_serial_checker.sv
// Scoreboard bench for crc8_serial_checker (DATA_BITS=32 main instance, DATA_BITS=8 side instance).
module tb_crc8_serial_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_in, bit_valid, sof;
  logic       busy, frame_done, crc_ok, crc_err, abort;
  logic [7:0] err_cnt;

  logic       d8_bit, d8_valid, d8_sof;
  logic       d8_busy, d8_done, d8_ok, d8_err, d8_abort;
  logic [7:0] d8_err_cnt;

  always #5 clk = ~clk;

  crc8_serial_checker #(.DATA_BITS(32), .POLY(8'h07), .INIT(8'h00)) u_dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .busy(busy), .frame_done(frame_done), .crc_ok(crc_ok), .crc_err(crc_err),
    .abort(abort), .err_cnt(err_cnt)
  );

  crc8_serial_checker #(.DATA_BITS(8), .POLY(8'h07), .INIT(8'h00)) u_dut8 (
    .clk(clk), .reset(reset), .bit_in(d8_bit), .bit_valid(d8_valid), .sof(d8_sof),
    .busy(d8_busy), .frame_done(d8_done), .crc_ok(d8_ok), .crc_err(d8_err),
    .abort(d8_abort), .err_cnt(d8_err_cnt)
  );

  typedef struct {
    logic ok;
    int   at;
  } exp_t;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  exp_t       done_q[$];
  int         abort_q[$];
  logic [7:0] exp_err = 8'h00;
  exp_t       mon_e;
  int         mon_a;

  always @(posedge clk) cyc <= cyc + 1;

  // Remainder of M(x)*x^8 mod (x^8+x^2+x+1) by long division of a 40-bit message.
  function automatic logic [7:0] ref_rem(input logic [39:0] m);
    logic [47:0] d;
    d = {m, 8'h00};
    for (int i = 47; i >= 8; i--)
      if (d[i]) d[i -: 9] = d[i -: 9] ^ 9'h107;
    return d[7:0];
  endfunction

  function automatic logic [7:0] ref_crc(input logic [31:0] p);
    logic [39:0] d;
    d = {p, 8'h00};
    for (int i = 39; i >= 8; i--)
      if (d[i]) d[i -: 9] = d[i -: 9] ^ 9'h107;
    return d[7:0];
  endfunction

  // Monitor: pops the scoreboard whenever the DUT reports a result or an abort.
  always @(negedge clk) begin
    if (frame_done) begin
      n_vec++;
      if (done_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: frame_done=1 at cyc %0d, required no pulse", cyc);
      end else begin
        mon_e = done_q.pop_front();
        if (!mon_e.ok && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        if (cyc !== mon_e.at || crc_ok !== mon_e.ok || crc_err !== !mon_e.ok || err_cnt !== exp_err) begin
          n_err++;
          $display("FAIL done_check: cyc=%0d ok=%b err=%b cnt=%0d, required cyc=%0d ok=%b err=%b cnt=%0d",
                   cyc, crc_ok, crc_err, err_cnt, mon_e.at, mon_e.ok, !mon_e.ok, exp_err);
        end
      end
    end else begin
      n_vec++;
      if (crc_ok !== 1'b0 || crc_err !== 1'b0) begin
        n_err++;
        $display("FAIL stray_result: ok=%b err=%b without frame_done, required 0/0", crc_ok, crc_err);
      end
    end
    if (abort) begin
      n_vec++;
      if (abort_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_abort: abort=1 at cyc %0d, required no pulse", cyc);
      end else begin
        mon_a = abort_q.pop_front();
        if (cyc !== mon_a) begin
          n_err++;
          $display("FAIL abort_time: abort at cyc %0d, required cyc %0d", cyc, mon_a);
        end
      end
    end
  end

  task automatic send_bit(input logic b, input logic s, input int gap_pct, input logic chk_busy);
    int guard;
    guard = 0;
    while (gap_pct > 0 && guard < 8 && $urandom_range(99, 0) < gap_pct) begin
      @(negedge clk);
      if (chk_busy) begin
        n_vec++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL busy_gap: busy=%b, required 1", busy);
        end
      end
      bit_valid = 1'b0;
      sof       = 1'($urandom_range(1, 0));
      bit_in    = 1'($urandom_range(1, 0));
      guard++;
    end
    @(negedge clk);
    if (chk_busy) begin
      n_vec++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL busy_frame: busy=%b, required 1", busy);
      end
    end
    bit_valid = 1'b1;
    bit_in    = b;
    sof       = s;
  endtask

  task automatic send_frame(input logic [31:0] pl, input logic [7:0] crc, input int gap_pct,
                            input logic exp_abort);
    logic [39:0] m;
    exp_t        e;
    m = {pl, crc};
    for (int i = 0; i < 40; i++) begin
      send_bit(m[39-i], (i == 0), gap_pct, (i != 0));
      if (i == 0 && exp_abort) abort_q.push_back(cyc + 1);
    end
    e.ok = (ref_rem(m) == 8'h00);
    e.at = cyc + 1;
    done_q.push_back(e);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bit_valid = 1'b0;
    sof       = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; sof = 1'b0;
    d8_bit = 1'b0; d8_valid = 1'b0; d8_sof = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, frame_done, crc_ok, crc_err, abort} !== 5'b0 || err_cnt !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state: flags=%b cnt=%0d, required 00000 / 0",
               {busy, frame_done, crc_ok, crc_err, abort}, err_cnt);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_data8();
    logic [15:0] f;
    logic [7:0]  crcs [2];
    crcs[0] = 8'h07;
    crcs[1] = 8'h06;
    for (int k = 0; k < 2; k++) begin
      f = {8'h01, crcs[k]};
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        d8_valid = 1'b1; d8_bit = f[15-i]; d8_sof = (i == 0);
      end
      @(negedge clk);
      d8_valid = 1'b0; d8_sof = 1'b0;
      n_vec++;
      if (d8_done !== 1'b1 || d8_ok !== (k == 0) || d8_err !== (k == 1) || d8_err_cnt !== 8'(k)) begin
        n_err++;
        $display("FAIL data8_frame%0d: done=%b ok=%b err=%b cnt=%0d, required 1/%b/%b/%0d",
                 k, d8_done, d8_ok, d8_err, d8_err_cnt, (k == 0), (k == 1), k);
      end
    end
  endtask

  task automatic test_good();
    send_frame(32'h0000_0001, 8'h07, 0, 1'b0);
    idle(3);
    n_vec++;
    if (done_q.size() != 0 || err_cnt !== 8'h00) begin
      n_err++;
      $display("FAIL good_frame: pending=%0d cnt=%0d, required 0/0", done_q.size(), err_cnt);
    end
  endtask

  task automatic test_bad();
    send_frame(32'h0000_0001, 8'h06, 0, 1'b0);
    idle(3);
    n_vec++;
    if (done_q.size() != 0 || err_cnt !== 8'h01) begin
      n_err++;
      $display("FAIL bad_frame: pending=%0d cnt=%0d, required 0/1", done_q.size(), err_cnt);
    end
  endtask

  task automatic test_gaps();
    send_frame(32'h0000_0001, 8'h07, 50, 1'b0);
    idle(3);
    n_vec++;
    if (done_q.size() != 0 || err_cnt !== 8'h01) begin
      n_err++;
      $display("FAIL gap_frame: pending=%0d cnt=%0d, required 0/1", done_q.size(), err_cnt);
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 17; i++)
      send_bit(1'($urandom_range(1, 0)), (i == 0), 0, (i != 0));
    send_frame(32'hC0FF_EE11, ref_crc(32'hC0FF_EE11), 0, 1'b1);
    idle(3);
    n_vec++;
    if (done_q.size() != 0 || abort_q.size() != 0 || err_cnt !== 8'h01) begin
      n_err++;
      $display("FAIL abort_frame: pending=%0d/%0d cnt=%0d, required 0/0/1",
               done_q.size(), abort_q.size(), err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(32'hDEAD_BEEF, ref_crc(32'hDEAD_BEEF), 0, 1'b0);
    send_frame(32'h1234_5678, ref_crc(32'h1234_5678), 0, 1'b0);
    send_frame(32'h8000_0000, ref_crc(32'h8000_0000) ^ 8'h01, 0, 1'b0);
    idle(3);
    n_vec++;
    if (done_q.size() != 0 || err_cnt !== 8'h02) begin
      n_err++;
      $display("FAIL b2b_frames: pending=%0d cnt=%0d, required 0/2", done_q.size(), err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [39:0] m;
    m = {32'h0000_0001, 8'h07};
    for (int i = 0; i < 10; i++) send_bit(m[39-i], (i == 0), 0, (i != 0));
    @(negedge clk);
    bit_valid = 1'b0; sof = 1'b0; reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({busy, frame_done, crc_ok, crc_err, abort} !== 5'b0 || err_cnt !== 8'h00) begin
      n_err++;
      $display("FAIL reset_mid: flags=%b cnt=%0d, required 00000 / 0",
               {busy, frame_done, crc_ok, crc_err, abort}, err_cnt);
    end
    reset   = 1'b0;
    exp_err = 8'h00;
    send_frame(32'h0000_0001, 8'h07, 0, 1'b0);
    idle(3);
    n_vec++;
    if (done_q.size() != 0 || abort_q.size() != 0 || err_cnt !== 8'h00) begin
      n_err++;
      $display("FAIL after_reset: pending=%0d/%0d cnt=%0d, required 0/0/0",
               done_q.size(), abort_q.size(), err_cnt);
    end
  endtask

  task automatic test_saturate();
    logic [31:0] p;
    for (int k = 0; k < 300; k++) begin
      p = $urandom;
      send_frame(p, ref_crc(p) ^ 8'h5A, 0, 1'b0);
    end
    idle(3);
    n_vec++;
    if (done_q.size() != 0 || err_cnt !== 8'hFF) begin
      n_err++;
      $display("FAIL saturate: pending=%0d cnt=%0d, required 0/255", done_q.size(), err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_data8();
    test_good();
    test_bad();
    test_gaps();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
